dmem_responder: RTL and testbench

Data-memory responder serving the CPU memory stage's load/store requests over a valid/ready request channel and a valid/ready response channel. Holds a word-addressed RAM, applies RISC-V funct3 byte/half/word selection with sign/zero extension on loads, and inserts a configurable number of wait states. Flags misaligned, out-of-range and illegal-funct3 accesses with an error response, leaving memory unmodified. One transaction is outstanding at a time.

---
 rtl/dmem_responder.sv | 213 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind valid/ready request and response
// channels, with RISC-V funct3 byte/half/word lanes and configurable wait states.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : request channel
//   resp_valid/resp_ready/resp_rdata/resp_err                  : response channel
module dmem_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH_WORDS   = 256,
    parameter int WAIT_CYCLES   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int WIX_W = ADDRESS_WIDTH - 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ready_q, ready_d;
    logic                     rvalid_q, rvalid_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     write_q, write_d;
    logic [2:0]               f3_q, f3_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [WIX_W-1:0] widx;
    logic [IDX_W-1:0] ram_idx;
    logic [1:0]       off;
    logic             in_range;
    logic             bad_f3;
    logic             misalign;
    logic             acc_err;
    logic [31:0]      mem_word;
    logic [31:0]      sh_word;
    logic [31:0]      load_data;
    logic [31:0]      wpat;
    logic [3:0]       be;
    logic             we;

    assign widx     = addr_q[ADDRESS_WIDTH-1:2];
    assign ram_idx  = widx[IDX_W-1:0];
    assign off      = addr_q[1:0];
    assign in_range = widx < WIX_W'(DEPTH_WORDS);

    // Stores only support 000/001/010; loads reject 011/110/111.
    assign bad_f3 = write_q ? (f3_q > 3'b010)
                            : (f3_q == 3'b011 || f3_q[2:1] == 2'b11);
    assign misalign = (f3_q[1:0] == 2'b01 && off[0])
                   || (f3_q[1:0] == 2'b10 && off != 2'b00);
    assign acc_err  = !in_range || bad_f3 || misalign;

    assign mem_word = mem[ram_idx];
    assign sh_word  = mem_word >> {off, 3'b000};

    always_comb begin
        load_data = 32'd0;
        case (f3_q)
            3'b000:  load_data = {{24{sh_word[7]}}, sh_word[7:0]};
            3'b100:  load_data = {24'd0, sh_word[7:0]};
            3'b001:  load_data = {{16{sh_word[15]}}, sh_word[15:0]};
            3'b101:  load_data = {16'd0, sh_word[15:0]};
            3'b010:  load_data = mem_word;
            default: load_data = 32'd0;
        endcase
    end

    // Store data is replicated across lanes; byte enables pick the target.
    always_comb begin
        wpat = wdata_q;
        be   = 4'b0000;
        case (f3_q)
            3'b000: begin
                wpat = {4{wdata_q[7:0]}};
                be   = 4'b0001 << off;
            end
            3'b001: begin
                wpat = {2{wdata_q[15:0]}};
                be   = off[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                wpat = wdata_q;
                be   = 4'b1111;
            end
            default: begin
                wpat = wdata_q;
                be   = 4'b0000;
            end
        endcase
    end

    // Reset forces IDLE asynchronously, so an aborted store never writes.
    assign we = (state_q == S_ACCESS) && write_q && !acc_err;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[ram_idx][8*i +: 8] <= wpat[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        write_d  = write_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (!ready_q) begin
                    ready_d = 1'b1;
                end else if (req_valid) begin
                    ready_d = 1'b0;
                    write_d = req_write;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata[31:0];
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACCESS: begin
                err_d    = acc_err;
                rdata_d  = (acc_err || write_q) ? 32'd0 : load_data;
                rvalid_d = 1'b1;
                state_d  = S_RESP;
            end
            default: begin
                if (resp_ready) begin
                    rvalid_d = 1'b0;
                    rdata_d  = 32'd0;
                    err_d    = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            f3_q     <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            write_q  <= write_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = rvalid_q;
    assign resp_rdata = DATA_WIDTH'(rdata_q);
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Instance A uses one wait state, instance B three wait states.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid_a, req_valid_b;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic        req_ready_a, resp_valid_a, resp_err_a;
    logic [31:0] resp_rdata_a;
    logic        req_ready_b, resp_valid_b, resp_err_b;
    logic [31:0] resp_rdata_b;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32),
        .DEPTH_WORDS(256), .WAIT_CYCLES(1)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
    );

    dmem_responder #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32),
        .DEPTH_WORDS(256), .WAIT_CYCLES(3)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request on a falling edge and hold it until accepted.
    task automatic start_req(input bit b, input bit w, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        req_write  = w;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        if (b) req_valid_b = 1'b1;
        else   req_valid_a = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (b ? req_ready_b : req_ready_a) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_addr    = 32'hFFFF_FFFC;
        req_wdata   = 32'h5555_5555;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout got=no_accept want=accept");
        end
    endtask

    // Count falling edges from acceptance until resp_valid is seen.
    task automatic wait_resp(input bit b, output int lat);
        lat = 0;
        while (!(b ? resp_valid_b : resp_valid_a) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat >= 50) begin
            errors++;
            $display("FAIL resp_timeout got=%0d want<50", lat);
        end
    endtask

    task automatic txn(input bit b, input bit w, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output int lat);
        resp_ready = 1'b1;
        start_req(b, w, f3, addr, wd);
        wait_resp(b, lat);
        rd = b ? resp_rdata_b : resp_rdata_a;
        er = b ? resp_err_b : resp_err_a;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready_a, resp_valid_a, resp_err_a, resp_rdata_a} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {req_ready_a, resp_valid_a, resp_err_a, resp_rdata_a});
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_release got=%b want=0", req_ready_a);
        end
        @(negedge clk);
        checks++;
        if (req_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release got=%b want=1", req_ready_a);
        end
    endtask

    task automatic test_word;
        logic [31:0] rd;
        logic er;
        int lat;
        txn(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
        checks++;
        if ({er, rd} !== 33'd0 || lat != 2) begin
            errors++;
            $display("FAIL sw_10 got=%b/%h/%0d want=0/0/2", er, rd, lat);
        end
        txn(0, 0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'hDEADBEEF} || lat != 2) begin
            errors++;
            $display("FAIL lw_10 got=%b/%h/%0d want=0/deadbeef/2", er, rd, lat);
        end
    endtask

    task automatic test_byte;
        logic [31:0] rd;
        logic er;
        int lat;
        txn(0, 1, 3'b000, 32'h11, 32'h000000A5, rd, er, lat);
        checks++;
        if ({er, rd} !== 33'd0) begin
            errors++;
            $display("FAIL sb_11 got=%b/%h want=0/0", er, rd);
        end
        txn(0, 0, 3'b000, 32'h11, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'hFFFFFFA5}) begin
            errors++;
            $display("FAIL lb_11 got=%b/%h want=0/ffffffa5", er, rd);
        end
        txn(0, 0, 3'b100, 32'h11, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h000000A5}) begin
            errors++;
            $display("FAIL lbu_11 got=%b/%h want=0/000000a5", er, rd);
        end
        txn(0, 0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'hDEADA5EF}) begin
            errors++;
            $display("FAIL lw_after_sb got=%b/%h want=0/deada5ef", er, rd);
        end
    endtask

    task automatic test_half;
        logic [31:0] rd;
        logic er;
        int lat;
        txn(0, 1, 3'b001, 32'h12, 32'h00008001, rd, er, lat);
        checks++;
        if ({er, rd} !== 33'd0) begin
            errors++;
            $display("FAIL sh_12 got=%b/%h want=0/0", er, rd);
        end
        txn(0, 0, 3'b001, 32'h12, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'hFFFF8001}) begin
            errors++;
            $display("FAIL lh_12 got=%b/%h want=0/ffff8001", er, rd);
        end
        txn(0, 0, 3'b101, 32'h12, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h00008001}) begin
            errors++;
            $display("FAIL lhu_12 got=%b/%h want=0/00008001", er, rd);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic er;
        int lat;
        txn(0, 0, 3'b010, 32'h13, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL lw_misalign got=%b/%h want=1/0", er, rd);
        end
        txn(0, 1, 3'b001, 32'h11, 32'h0000FFFF, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL sh_misalign got=%b/%h want=1/0", er, rd);
        end
        txn(0, 0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h8001A5EF}) begin
            errors++;
            $display("FAIL lw_after_bad_sh got=%b/%h want=0/8001a5ef", er, rd);
        end
        txn(0, 0, 3'b010, 32'h400, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL lw_range got=%b/%h want=1/0", er, rd);
        end
        txn(0, 0, 3'b011, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL load_f3_011 got=%b/%h want=1/0", er, rd);
        end
        txn(0, 1, 3'b100, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL store_f3_100 got=%b/%h want=1/0", er, rd);
        end
        txn(0, 0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h8001A5EF}) begin
            errors++;
            $display("FAIL lw_after_bad_f3 got=%b/%h want=0/8001a5ef", er, rd);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        resp_ready = 1'b0;
        start_req(0, 0, 3'b010, 32'h10, 32'h0);
        wait_resp(0, lat);
        checks++;
        if ({resp_err_a, resp_rdata_a} !== {1'b0, 32'h8001A5EF}) begin
            errors++;
            $display("FAIL hold_first got=%b/%h want=0/8001a5ef",
                     resp_err_a, resp_rdata_a);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({resp_valid_a, req_ready_a, resp_err_a, resp_rdata_a}
                !== {2'b10, 1'b0, 32'h8001A5EF}) begin
                errors++;
                $display("FAIL hold_cycle%0d got=%b%b%b/%h want=100/8001a5ef",
                         i, resp_valid_a, req_ready_a, resp_err_a, resp_rdata_a);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({resp_valid_a, req_ready_a} !== 2'b01) begin
            errors++;
            $display("FAIL hold_release got=%b%b want=01",
                     resp_valid_a, req_ready_a);
        end
    endtask

    task automatic test_abort;
        logic [31:0] rd;
        logic er;
        int lat;
        txn(1, 1, 3'b010, 32'h20, 32'h11112222, rd, er, lat);
        checks++;
        if ({er, rd} !== 33'd0 || lat != 4) begin
            errors++;
            $display("FAIL sw_20_w3 got=%b/%h/%0d want=0/0/4", er, rd, lat);
        end
        start_req(1, 1, 3'b010, 32'h20, 32'h12345678);
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready_b, resp_valid_b, resp_err_b, resp_rdata_b} !== 35'd0) begin
            errors++;
            $display("FAIL abort_outputs got=%h want=0",
                     {req_ready_b, resp_valid_b, resp_err_b, resp_rdata_b});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready_b !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready_release got=%b want=0", req_ready_b);
        end
        @(negedge clk);
        checks++;
        if (req_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready_after got=%b want=1", req_ready_b);
        end
        txn(1, 0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h11112222} || lat != 4) begin
            errors++;
            $display("FAIL lw_20_after_abort got=%b/%h/%0d want=0/11112222/4",
                     er, rd, lat);
        end
    endtask

    initial begin
        rst         = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_write   = 1'b0;
        req_funct3  = 3'b000;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        resp_ready  = 1'b1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
